mmio_bus_bridge: RTL and testbench

Sits directly downstream of the `cpu` byte bus (`mem_a`/`mem_dout`/`mem_wr`/`mem_din`). Each access is routed to the 128 KB block RAM or to the memory-mapped I/O space. The block produces `io_buffer_full` for the CPU and implements the I/O registers:
- UART TX FIFO with handshake,
- UART RX byte read,
- 32-bit cycle counter,
- program-stop flag.

Read data returns one cycle after the request, matching the CPU's memory-timing contract.

---
 rtl/mmio_bus_bridge.sv | 162 ++++++++++++++++
 tb/tb_mmio_bus_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_bridge.sv
// Purpose: routes CPU byte accesses to block RAM or the MMIO registers (UART TX FIFO, UART RX, cycle counter, stop flag).
// Latency: reads return on cpu_din one cycle after the request; writes take effect at the next clock edge.
// Backpressure: io_buffer_full warns the CPU one slot early; a TX push into a full FIFO with no pop is dropped and flagged.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  CPU access qualifier
//   cpu_a/cpu_dout/cpu_wr   CPU request (byte address, write data, write strobe)
//   cpu_din                 read data, valid one cycle after the request, held until the next read completes
//   io_buffer_full          TX FIFO has at most one free slot
//   ram_en/ram_wr/ram_a/ram_din/ram_dout   128 KB block RAM port (read data one cycle after ram_en)
//   tx_data/tx_valid/tx_ready              UART TX handshake from the FIFO head
//   rx_data/rx_valid/rx_pop                UART RX byte and consume pulse
//   program_finished, tx_overflow          sticky status flags
module mmio_bus_bridge #(
  parameter int TX_FIFO_WIDTH = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic        ram_en,
  output logic        ram_wr,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_finished,
  output logic        tx_overflow
);

  localparam int DEPTH = 1 << TX_FIFO_WIDTH;
  localparam logic [TX_FIFO_WIDTH:0] DEPTH_CNT = {1'b1, {TX_FIFO_WIDTH{1'b0}}};
  localparam logic [TX_FIFO_WIDTH:0] FULL_MARK = {1'b0, {TX_FIFO_WIDTH{1'b1}}};

  // Where the byte for a read issued last cycle comes from; NONE keeps cpu_din held.
  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_IO, SRC_ZERO} src_t;

  src_t        src_q, src_nxt;
  logic        sel_ram, sel_io, rd_acc, wr_acc;
  logic [2:0]  io_off;
  logic        snap_en, stop_wr, push_req, push_ok, tx_pop;
  logic [7:0]  push_dat, io_val, io_q, hold_q;
  logic [31:0] cycle_cnt, cnt_snap;

  logic [7:0]               fifo_mem [DEPTH];
  logic [TX_FIFO_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [TX_FIFO_WIDTH:0]   fifo_cnt;

  // Only a 256 KB window is decoded; upper address bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_a[31:18];

  // Address decode and access qualification
  assign sel_ram = ~cpu_a[17];
  assign sel_io  = cpu_a[17] & cpu_a[16];
  assign io_off  = cpu_a[2:0];
  assign rd_acc  = rdy_in & ~cpu_wr;
  assign wr_acc  = rdy_in & cpu_wr;

  assign ram_en  = rdy_in & sel_ram;
  assign ram_wr  = ram_en & cpu_wr;
  assign ram_a   = cpu_a[16:0];
  assign ram_din = cpu_dout;

  assign rx_pop   = rd_acc & sel_io & (io_off == 3'd0) & rx_valid;
  assign snap_en  = rd_acc & sel_io & (io_off == 3'd4);
  assign stop_wr  = wr_acc & sel_io & (io_off == 3'd4);
  // A zero byte on the data port is a no-op; the stop write enqueues a zero as an end marker.
  assign push_req = stop_wr | (wr_acc & sel_io & (io_off == 3'd0) & (cpu_dout != 8'h00));
  assign push_dat = stop_wr ? 8'h00 : cpu_dout;

  always_comb begin
    io_val = 8'h00;
    case (io_off)
      3'd0:    io_val = rx_valid ? rx_data : 8'h00;
      3'd4:    io_val = cycle_cnt[7:0];
      3'd5:    io_val = cnt_snap[15:8];
      3'd6:    io_val = cnt_snap[23:16];
      3'd7:    io_val = cnt_snap[31:24];
      default: io_val = 8'h00;
    endcase
  end

  always_comb begin
    src_nxt = SRC_NONE;
    if (rd_acc) begin
      if (sel_ram)     src_nxt = SRC_RAM;
      else if (sel_io) src_nxt = SRC_IO;
      else             src_nxt = SRC_ZERO;
    end
  end

  // RAM data arrives registered by the RAM itself, so the return mux can use it
  // directly in the cycle after the request; hold_q keeps the last byte afterwards.
  always_comb begin
    case (src_q)
      SRC_RAM:  cpu_din = ram_dout;
      SRC_IO:   cpu_din = io_q;
      SRC_ZERO: cpu_din = 8'h00;
      default:  cpu_din = hold_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_q            <= SRC_NONE;
      io_q             <= 8'h00;
      hold_q           <= 8'h00;
      cycle_cnt        <= 32'd0;
      cnt_snap         <= 32'd0;
      program_finished <= 1'b0;
    end else begin
      src_q     <= src_nxt;
      io_q      <= io_val;
      hold_q    <= cpu_din;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (snap_en) cnt_snap <= cycle_cnt;
      if (stop_wr) program_finished <= 1'b1;
    end
  end

  // TX FIFO: a push into a full FIFO still fits when the head leaves in the same cycle.
  assign tx_valid       = (fifo_cnt != '0);
  assign tx_data        = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign tx_pop         = tx_valid & tx_ready;
  assign push_ok        = push_req & ((fifo_cnt < DEPTH_CNT) | tx_pop);
  assign io_buffer_full = (fifo_cnt >= FULL_MARK);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, tx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req && !push_ok) tx_overflow <= 1'b1;
    end
  end

  // Storage needs no reset: tx_data is masked while the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_dat;
  end

endmodule

// File: tb/tb_mmio_bus_bridge.sv
module tb_mmio_bus_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic        ram_en, ram_wr;
  logic [16:0] ram_a;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_finished;
  logic        tx_overflow;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  tx_exp[$];
  logic [31:0] tb_cyc;
  logic [31:0] snap;
  logic        rd_pend = 1'b0;
  logic [7:0]  ram_mem [0:131071];

  mmio_bus_bridge #(.TX_FIFO_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_din(ram_din), .ram_dout(ram_dout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .program_finished(program_finished), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Block RAM model: registered read data one cycle after ram_en.
  always @(posedge clk_in) begin
    if (ram_en) begin
      if (ram_wr) ram_mem[ram_a] <= ram_din;
      else        ram_dout <= ram_mem[ram_a];
    end
  end

  // Reference cycle counter: free-running, cleared by reset.
  always @(posedge clk_in) tb_cyc <= rst_in ? 32'd0 : tb_cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read monitor: a read accepted at an edge must show its byte in the following cycle.
  always @(posedge clk_in) rd_pend <= rdy_in & ~cpu_wr & ~rst_in;

  always @(negedge clk_in) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else                   chk("rd_data", cpu_din, exp_q.pop_front());
    end
  end

  // TX monitor: every byte handed to the UART must be the next expected byte.
  always @(negedge clk_in) begin
    if (tx_valid && tx_ready) begin
      if (tx_exp.size() == 0) chk("tx_unexpected", tx_data, 32'hFFFF);
      else                    chk("tx_data", tx_data, tx_exp.pop_front());
    end
  end

  task automatic next_cyc();
    @(posedge clk_in);
    #1;
    rdy_in   = 1'b0;
    cpu_wr   = 1'b0;
    cpu_a    = 32'd0;
    cpu_dout = 8'h00;
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp);
    exp_q.push_back(exp);
    rdy_in = 1'b1;
    cpu_wr = 1'b0;
    cpu_a  = a;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    rdy_in   = 1'b1;
    cpu_wr   = 1'b1;
    cpu_a    = a;
    cpu_dout = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b0; cpu_a = 32'd0; cpu_dout = 8'h00; cpu_wr = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_cpu_din", cpu_din, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_pop", rx_pop, 0);
    chk("rst_io_full", io_buffer_full, 0);
    chk("rst_finished", program_finished, 0);
    chk("rst_overflow", tx_overflow, 0);
    chk("rst_ram_en", ram_en, 0);
    next_cyc();
    rst_in = 1'b0;
    repeat (700) next_cyc();

    // Counter snapshot: later reads of bytes 1..3 must return the snapshot, not the live count
    snap = tb_cyc;
    rd(32'h30004, tb_cyc[7:0]);
    next_cyc();
    repeat (300) next_cyc();
    rd(32'h30005, snap[15:8]);  next_cyc();
    rd(32'h30006, snap[23:16]); next_cyc();
    rd(32'h30007, snap[31:24]); next_cyc();

    // RAM write/read and unmapped space
    wr(32'h00123, 8'hA5);
    @(negedge clk_in);
    chk("ram_wr_en", ram_en, 1);
    chk("ram_wr_we", ram_wr, 1);
    chk("ram_wr_addr", ram_a, 32'h123);
    chk("ram_wr_data", ram_din, 8'hA5);
    next_cyc();
    rd(32'h00123, 8'hA5);
    @(negedge clk_in);
    chk("ram_rd_en", ram_en, 1);
    chk("ram_rd_we", ram_wr, 0);
    next_cyc();
    wr(32'h1FFFF, 8'h5A); next_cyc();
    wr(32'h2FFFF, 8'h66);
    @(negedge clk_in);
    chk("unmapped_wr_ram_en", ram_en, 0);
    next_cyc();
    rd(32'h1FFFF, 8'h5A); next_cyc();
    rd(32'h20005, 8'h00);
    @(negedge clk_in);
    chk("unmapped_rd_ram_en", ram_en, 0);
    next_cyc();
    rd(32'h00123, 8'hA5); next_cyc();
    rd(32'h30002, 8'h00); next_cyc();

    // UART TX: zero byte is skipped
    wr(32'h30000, 8'h48); tx_exp.push_back(8'h48); next_cyc();
    wr(32'h30000, 8'h69); tx_exp.push_back(8'h69); next_cyc();
    wr(32'h30000, 8'h00); next_cyc();
    wr(32'h30000, 8'h21); tx_exp.push_back(8'h21); next_cyc();
    @(negedge clk_in);
    chk("tx_valid_loaded", tx_valid, 1);
    chk("tx_head", tx_data, 8'h48);
    chk("tx3_not_full", io_buffer_full, 0);
    next_cyc();
    tx_ready = 1'b1;
    repeat (5) next_cyc();
    @(negedge clk_in);
    chk("tx_drained", tx_valid, 0);
    chk("tx_queue_left", tx_exp.size(), 0);
    next_cyc();
    tx_ready = 1'b0;

    // FIFO full behaviour
    for (int i = 0; i < 6; i++) begin
      wr(32'h30000, 8'h11 + 8'(i)); tx_exp.push_back(8'h11 + 8'(i)); next_cyc();
    end
    @(negedge clk_in);
    chk("full_after6", io_buffer_full, 0);
    next_cyc();
    wr(32'h30000, 8'h17); tx_exp.push_back(8'h17); next_cyc();
    @(negedge clk_in);
    chk("full_after7", io_buffer_full, 1);
    next_cyc();
    wr(32'h30000, 8'h18); tx_exp.push_back(8'h18); next_cyc();
    @(negedge clk_in);
    chk("ovf_after8", tx_overflow, 0);
    next_cyc();
    wr(32'h30000, 8'h19); next_cyc();
    @(negedge clk_in);
    chk("ovf_after9", tx_overflow, 1);
    next_cyc();
    tx_ready = 1'b1;
    wr(32'h30000, 8'h1A); tx_exp.push_back(8'h1A); next_cyc();
    @(negedge clk_in);
    chk("full_after_pushpop", io_buffer_full, 1);
    repeat (10) next_cyc();
    @(negedge clk_in);
    chk("full_drained", tx_valid, 0);
    chk("full_queue_left", tx_exp.size(), 0);
    next_cyc();
    tx_ready = 1'b0;

    // Stop flag enqueues a zero byte
    wr(32'h30004, 8'h00); tx_exp.push_back(8'h00);
    @(negedge clk_in);
    chk("stop_before_edge", program_finished, 0);
    next_cyc();
    @(negedge clk_in);
    chk("stop_set", program_finished, 1);
    chk("stop_tx_valid", tx_valid, 1);
    chk("stop_tx_zero", tx_data, 8'h00);
    next_cyc();
    tx_ready = 1'b1;
    repeat (2) next_cyc();
    @(negedge clk_in);
    chk("stop_drained", tx_valid, 0);
    next_cyc();
    tx_ready = 1'b0;

    // UART RX
    rx_valid = 1'b1; rx_data = 8'h3C;
    rd(32'h30000, 8'h3C);
    @(negedge clk_in);
    chk("rx_pop_valid", rx_pop, 1);
    next_cyc();
    rx_valid = 1'b0; rx_data = 8'h99;
    rd(32'h30000, 8'h00);
    @(negedge clk_in);
    chk("rx_pop_empty", rx_pop, 0);
    next_cyc();
    rx_valid = 1'b1; rx_data = 8'h3C;
    cpu_a = 32'h30000;
    @(negedge clk_in);
    chk("rx_pop_rdy_low", rx_pop, 0);
    next_cyc();
    rx_valid = 1'b0;

    // rdy_in low: nothing honoured, counter keeps running
    cpu_wr = 1'b1; cpu_a = 32'h30000; cpu_dout = 8'h77;
    @(negedge clk_in);
    chk("rdylow_ram_en", ram_en, 0);
    next_cyc();
    @(negedge clk_in);
    chk("rdylow_no_push", tx_valid, 0);
    next_cyc();
    cpu_wr = 1'b1; cpu_a = 32'h00123; cpu_dout = 8'h00;
    @(negedge clk_in);
    chk("rdylow_ram_wr_en", ram_en, 0);
    next_cyc();
    rd(32'h00123, 8'hA5); next_cyc();
    rd(32'h30004, tb_cyc[7:0]); next_cyc();

    // Reset mid-access drops the pending read and empties the FIFO
    wr(32'h30000, 8'h55); next_cyc();
    rd(32'h00123, 8'hA5); next_cyc();
    rdy_in = 1'b1; cpu_wr = 1'b0; cpu_a = 32'h1FFFF; rst_in = 1'b1;
    next_cyc();
    rst_in = 1'b0;
    tx_exp.delete();
    @(negedge clk_in);
    chk("rst_mid_cpu_din", cpu_din, 0);
    chk("rst_mid_tx_valid", tx_valid, 0);
    chk("rst_mid_finished", program_finished, 0);
    chk("rst_mid_overflow", tx_overflow, 0);
    next_cyc();
    rd(32'h30005, 8'h00); next_cyc();
    rd(32'h30004, tb_cyc[7:0]); next_cyc();
    next_cyc();
    @(negedge clk_in);
    chk("rd_queue_left", exp_q.size(), 0);
    chk("tx_queue_final", tx_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
